// File: rtl/store_narrow_rmw_pkg.sv
// Shared definitions for the narrow store unit: size codes, FSM state
// encodings, lane-select constants and the request legality check.
package store_narrow_rmw_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    localparam logic [3:0] BE_LANE0 = 4'b0001;
    localparam logic [3:0] BE_LOHALF = 4'b0011;
    localparam logic [3:0] BE_HIHALF = 4'b1100;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Reserved size or an address not aligned to the access size.
    function automatic logic badRequest(
        input logic [1:0] size,
        input logic [1:0] lane
    );
        logic bad;
        bad = 1'b0;
        unique case (1'b1)
            size == SZ_RSVD: bad = 1'b1;
            size == SZ_HALF: bad = lane[0];
            size == SZ_WORD: bad = (lane != 2'b00);
            size == SZ_BYTE: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_narrow_rmw_if.sv
// Store request and data-memory bus bundle for store_narrow_rmw.
// slave: the store unit; master: requester plus data memory.
interface store_narrow_rmw_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [1:0]        req_size;
    logic              done;
    logic              err;
    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_size, mem_rdata,
        output req_ready, done, err, mem_re, mem_we,
        output mem_addr, mem_wdata, mem_be
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_size, mem_rdata,
        input  req_ready, done, err, mem_re, mem_we,
        input  mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/store_narrow_rmw_lane_merge.sv
// store_lane_merge: combinational lane placement for sub-word stores.
// Ports: oldWord/wdata/size/lane in; merged (RMW word), repl, be out.
module store_lane_merge
    import store_narrow_rmw_pkg::*;
(
    input  logic [31:0] oldWord,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    output logic [31:0] merged,
    output logic [31:0] repl,
    output logic [3:0]  be
);

    always_comb begin
        repl = wdata;
        be   = BE_WORD;
        case (size)
            SZ_BYTE: begin
                repl = {4{wdata[7:0]}};
                be   = BE_LANE0 << lane;
            end
            SZ_HALF: begin
                repl = {2{wdata[15:0]}};
                be   = lane[1] ? BE_HIHALF : BE_LOHALF;
            end
            default: ;
        endcase
    end

    // Replicated data lands in every lane; enables pick which survive.
    always_comb begin
        merged = oldWord;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = repl[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/store_narrow_rmw.sv
// store_narrow_rmw: narrows sb/sh/sw data into word-wide data memory,
// using read-modify-write for sub-word stores.
// Ports: clk, reset_n (async, active-low), bus (store_narrow_rmw_if.slave).
// Macro STORE_NARROW_BE_EN: byte-enable writes replace read-modify-write.
module store_narrow_rmw
    import store_narrow_rmw_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int MEM_RD_LAT = 1
) (
    input  logic clk,
    input  logic reset_n,
    store_narrow_rmw_if.slave bus
);

    localparam logic [1:0] LAT_LOAD = 2'(MEM_RD_LAT - 1);

`ifdef STORE_NARROW_BE_EN
    localparam bit BE_EN = 1'b1;
`else
    localparam bit BE_EN = 1'b0;
`endif

    logic [2:0]        state;
    logic [1:0]        cnt;
    logic [1:0]        laneReg;
    logic [1:0]        sizeReg;
    logic [31:0]       wdataReg;
    logic [31:0]       memWdata;
    logic [ADDR_W-3:0] memAddr;

    logic        idle;
    logic [31:0] mWdata;
    logic [1:0]  mSize;
    logic [1:0]  mLane;
    logic [31:0] merged;
    logic [31:0] repl;
    logic [3:0]  laneBe;

    assign idle = (state == ST_IDLE);

    // While idle the merger sees the incoming request so direct writes
    // can be formed on accept; afterwards it sees the latched store.
    assign mWdata = idle ? bus.req_wdata : wdataReg;
    assign mSize  = idle ? bus.req_size : sizeReg;
    assign mLane  = idle ? bus.req_addr[1:0] : laneReg;

    store_lane_merge uMerge (
        .oldWord (bus.mem_rdata),
        .wdata   (mWdata),
        .size    (mSize),
        .lane    (mLane),
        .merged  (merged),
        .repl    (repl),
        .be      (laneBe)
    );

`ifdef STORE_NARROW_BE_EN
    logic [3:0] memBe;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cnt      <= 2'd0;
            laneReg  <= 2'd0;
            sizeReg  <= SZ_BYTE;
            wdataReg <= 32'd0;
            memWdata <= 32'd0;
            memAddr  <= '0;
`ifdef STORE_NARROW_BE_EN
            memBe    <= BE_WORD;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        memAddr  <= bus.req_addr[ADDR_W-1:2];
                        laneReg  <= bus.req_addr[1:0];
                        sizeReg  <= bus.req_size;
                        wdataReg <= bus.req_wdata;
                        if (badRequest(bus.req_size,
                                       bus.req_addr[1:0])) begin
                            state <= ST_ERR;
                        end else if (BE_EN ||
                                     bus.req_size == SZ_WORD) begin
                            memWdata <= repl;
`ifdef STORE_NARROW_BE_EN
                            memBe    <= laneBe;
`endif
                            state    <= ST_WR;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    cnt   <= LAT_LOAD;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == 2'd0) begin
                        memWdata <= merged;
                        state    <= ST_WR;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                ST_WR:   state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = idle;
    assign bus.mem_re    = (state == ST_RD);
    assign bus.mem_we    = (state == ST_WR);
    assign bus.done      = (state == ST_WR);
    assign bus.err       = (state == ST_ERR);
    assign bus.mem_addr  = memAddr;
    assign bus.mem_wdata = memWdata;

`ifdef STORE_NARROW_BE_EN
    assign bus.mem_be = memBe;
`else
    assign bus.mem_be = BE_WORD;
    logic unusedBe;
    assign unusedBe = ^laneBe;
`endif

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Directed bench for store_narrow_rmw: two instances, read latency 1 and 3,
// each fed by a small data-memory model honouring its latency.
module tb_store_narrow_rmw;
    import store_narrow_rmw_pkg::*;

`ifdef STORE_NARROW_BE_EN
    localparam bit BE = 1'b1;
`else
    localparam bit BE = 1'b0;
`endif
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    store_narrow_rmw_if #(.ADDR_W(32)) ifA ();
    store_narrow_rmw_if #(.ADDR_W(32)) ifB ();

    store_narrow_rmw #(.ADDR_W(32), .MEM_RD_LAT(LAT_A)) dutA (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifA)
    );

    store_narrow_rmw #(.ADDR_W(32), .MEM_RD_LAT(LAT_B)) dutB (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifB)
    );

    logic [1:0]       rv;
    logic [1:0][31:0] ra;
    logic [1:0][31:0] rw;
    logic [1:0][1:0]  rs;
    logic [1:0][31:0] mw;

    assign ifA.req_valid = rv[0];
    assign ifA.req_addr  = ra[0];
    assign ifA.req_wdata = rw[0];
    assign ifA.req_size  = rs[0];
    assign ifB.req_valid = rv[1];
    assign ifB.req_addr  = ra[1];
    assign ifB.req_wdata = rw[1];
    assign ifB.req_size  = rs[1];

    // Read data is valid only in the cycle MEM_RD_LAT after mem_re.
    logic [4:0] histA = 5'd0;
    logic [4:0] histB = 5'd0;
    always @(posedge clk) begin
        histA <= {histA[3:0], ifA.mem_re};
        histB <= {histB[3:0], ifB.mem_re};
    end
    assign ifA.mem_rdata = histA[LAT_A-1] ? mw[0] : 32'hBAD0BAD0;
    assign ifB.mem_rdata = histB[LAT_B-1] ? mw[1] : 32'hBAD0BAD0;

    logic [1:0]       rdy, dn, er, re, we;
    logic [1:0][29:0] ma;
    logic [1:0][31:0] wd;
    logic [1:0][3:0]  be;

    assign rdy[0] = ifA.req_ready;
    assign dn[0]  = ifA.done;
    assign er[0]  = ifA.err;
    assign re[0]  = ifA.mem_re;
    assign we[0]  = ifA.mem_we;
    assign ma[0]  = ifA.mem_addr;
    assign wd[0]  = ifA.mem_wdata;
    assign be[0]  = ifA.mem_be;
    assign rdy[1] = ifB.req_ready;
    assign dn[1]  = ifB.done;
    assign er[1]  = ifB.err;
    assign re[1]  = ifB.mem_re;
    assign we[1]  = ifB.mem_we;
    assign ma[1]  = ifB.mem_addr;
    assign wd[1]  = ifB.mem_wdata;
    assign be[1]  = ifB.mem_be;

    int vectors = 0;
    int miscompares = 0;

    int          tLat;
    logic        tRe, tWe, tEr, tRdyBusy, tRdyAfter, tPulseAfter;
    logic [31:0] tWd;
    logic [29:0] tWa;
    logic [3:0]  tBe;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one store; cycle 0 is the accept cycle.
    task automatic runOp(input int u, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] s);
        @(negedge clk);
        rv[u] = 1'b1;
        ra[u] = a;
        rw[u] = d;
        rs[u] = s;
        chk("ready_at_request", 32'(rdy[u]), 32'd1);
        @(posedge clk);
        #1;
        rv[u] = 1'b0;
        ra[u] = 32'hFFFF_FFFC;
        rw[u] = 32'h0;
        rs[u] = SZ_WORD;
        tLat = -1;
        tRe = 1'b0;
        tWe = 1'b0;
        tEr = 1'b0;
        tRdyBusy = 1'b0;
        tWd = '0;
        tWa = '0;
        tBe = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (re[u]) tRe = 1'b1;
            if (we[u]) tWe = 1'b1;
            if (rdy[u]) tRdyBusy = 1'b1;
            if (dn[u] || er[u]) begin
                tLat = i;
                tEr = er[u];
                tWd = wd[u];
                tWa = ma[u];
                tBe = be[u];
                break;
            end
        end
        @(negedge clk);
        tRdyAfter = rdy[u];
        tPulseAfter = dn[u] | er[u] | we[u];
    endtask

    task automatic checkOp(input string n, input int expLat,
                           input logic expRe, input logic expErr,
                           input logic [31:0] expWd,
                           input logic [29:0] expWa,
                           input logic [3:0] expBe);
        chk({n, "_latency"}, 32'(tLat), 32'(expLat));
        chk({n, "_mem_re_seen"}, 32'(tRe), 32'(expRe));
        chk({n, "_err"}, 32'(tEr), 32'(expErr));
        chk({n, "_mem_we_seen"}, 32'(tWe), 32'(!expErr));
        chk({n, "_mem_addr"}, 32'(tWa), 32'(expWa));
        if (!expErr) begin
            chk({n, "_mem_wdata"}, tWd, expWd);
            chk({n, "_mem_be"}, 32'(tBe), 32'(expBe));
        end
        chk({n, "_ready_busy"}, 32'(tRdyBusy), 32'd0);
        chk({n, "_ready_after"}, 32'(tRdyAfter), 32'd1);
        chk({n, "_pulse_after"}, 32'(tPulseAfter), 32'd0);
    endtask

    initial begin
        logic seenWe;
        rv = '0;
        ra = '0;
        rw = '0;
        rs = '0;
        mw = '0;

        #12;
        chk("rst_ready", 32'(rdy[0]), 32'd1);
        chk("rst_done", 32'(dn[0]), 32'd0);
        chk("rst_err", 32'(er[0]), 32'd0);
        chk("rst_mem_re", 32'(re[0]), 32'd0);
        chk("rst_mem_we", 32'(we[0]), 32'd0);
        chk("rst_mem_addr", 32'(ma[0]), 32'd0);
        chk("rst_mem_wdata", wd[0], 32'd0);
        chk("rst_mem_be", 32'(be[0]), 32'hF);
        @(negedge clk);
        reset_n = 1'b1;

        runOp(0, 32'h10, 32'hDEADBEEF, SZ_WORD);
        checkOp("sw_10", 1, 1'b0, 1'b0, 32'hDEADBEEF, 30'h4, 4'hF);

        mw[0] = 32'h11223344;
        runOp(0, 32'h13, 32'h000000AA, SZ_BYTE);
        checkOp("sb_13_lat1", BE ? 1 : 2 + LAT_A, !BE, 1'b0,
                BE ? 32'hAAAAAAAA : 32'hAA223344, 30'h4,
                BE ? 4'b1000 : 4'hF);

        mw[1] = 32'h11223344;
        runOp(1, 32'h22, 32'h0000BEEF, SZ_HALF);
        checkOp("sh_22_lat3", BE ? 1 : 2 + LAT_B, !BE, 1'b0,
                BE ? 32'hBEEFBEEF : 32'hBEEF3344, 30'h8,
                BE ? 4'b1100 : 4'hF);

        runOp(1, 32'h10, 32'h12345677, SZ_BYTE);
        checkOp("sb_10_lat3", BE ? 1 : 2 + LAT_B, !BE, 1'b0,
                BE ? 32'h77777777 : 32'h11223377, 30'h4,
                BE ? 4'b0001 : 4'hF);

        runOp(0, 32'h20, 32'hFFFFCAFE, SZ_HALF);
        checkOp("sh_20_lat1", BE ? 1 : 2 + LAT_A, !BE, 1'b0,
                BE ? 32'hCAFECAFE : 32'h1122CAFE, 30'h8,
                BE ? 4'b0011 : 4'hF);

        runOp(0, 32'h11, 32'h0000005A, SZ_BYTE);
        checkOp("sb_11_lat1", BE ? 1 : 2 + LAT_A, !BE, 1'b0,
                BE ? 32'h5A5A5A5A : 32'h11225A44, 30'h4,
                BE ? 4'b0010 : 4'hF);

        runOp(1, 32'h3FFC, 32'h0BADF00D, SZ_WORD);
        checkOp("sw_3ffc", 1, 1'b0, 1'b0, 32'h0BADF00D, 30'hFFF, 4'hF);

        runOp(0, 32'h21, 32'h0000BEEF, SZ_HALF);
        checkOp("sh_21_misal", 1, 1'b0, 1'b1, 32'h0, 30'h8, 4'hF);

        runOp(0, 32'h12, 32'h01020304, SZ_WORD);
        checkOp("sw_12_misal", 1, 1'b0, 1'b1, 32'h0, 30'h4, 4'hF);

        runOp(1, 32'h10, 32'h01020304, SZ_RSVD);
        checkOp("size_11", 1, 1'b0, 1'b1, 32'h0, 30'h4, 4'hF);

        // Reset while the latency-3 unit waits for read data.
        @(negedge clk);
        rv[1] = 1'b1;
        ra[1] = 32'h22;
        rw[1] = 32'h0000BEEF;
        rs[1] = SZ_HALF;
        @(posedge clk);
        #1;
        rv[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (!BE) begin
            chk("pre_rst_busy", 32'(rdy[1]), 32'd0);
        end
        reset_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(rdy[1]), 32'd1);
        chk("midrst_done", 32'(dn[1]), 32'd0);
        chk("midrst_err", 32'(er[1]), 32'd0);
        chk("midrst_mem_re", 32'(re[1]), 32'd0);
        chk("midrst_mem_we", 32'(we[1]), 32'd0);
        chk("midrst_mem_addr", 32'(ma[1]), 32'd0);
        chk("midrst_mem_wdata", wd[1], 32'd0);
        chk("midrst_mem_be", 32'(be[1]), 32'hF);
        @(negedge clk);
        reset_n = 1'b1;
        seenWe = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (we[1] || dn[1]) seenWe = 1'b1;
        end
        chk("post_rst_no_write", 32'(seenWe), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
